// File: rtl/iq_byte_packer_pkg.sv
// Shared constants, FSM encoding and byte-select helper for the IQ byte packer.
package iq_byte_packer_pkg;

    localparam int IQ_WIDTH       = 24;
    localparam int BYTES_PER_PAIR = 6;
    localparam int PAIR_WIDTH     = 2 * IQ_WIDTH;
    localparam int IDX_WIDTH      = 3;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(BYTES_PER_PAIR - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Byte 0 is the most significant byte of I, byte 5 the least significant of Q.
    function automatic logic [7:0] pair_byte(input logic [PAIR_WIDTH-1:0] pair,
                                             input logic [IDX_WIDTH-1:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = pair[47:40];
            3'd1:    b = pair[39:32];
            3'd2:    b = pair[31:24];
            3'd3:    b = pair[23:16];
            3'd4:    b = pair[15:8];
            3'd5:    b = pair[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/iq_byte_packer_if.sv
// Sample input strobe and byte output stream of the IQ byte packer.
interface iq_byte_packer_if;

    logic                                  in_strobe;
    logic [iq_byte_packer_pkg::IQ_WIDTH-1:0] in_data_I;
    logic [iq_byte_packer_pkg::IQ_WIDTH-1:0] in_data_Q;
    logic [7:0]                            out_data;
    logic                                  out_valid;
    logic                                  out_ready;
    logic                                  out_first;
    logic                                  out_last;

    modport master (
        output in_strobe, in_data_I, in_data_Q, out_ready,
        input  out_data, out_valid, out_first, out_last
    );

    modport slave (
        input  in_strobe, in_data_I, in_data_Q, out_ready,
        output out_data, out_valid, out_first, out_last
    );

endinterface

// File: rtl/iq_fifo.sv
// Synchronous FIFO with combinational read of the head entry, zero-latency level.
// Push when full and pop when empty are ignored.
module iq_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             wr_en, rd_en;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign wr_en   = push && !full;
    assign rd_en   = pop && !empty;

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/iq_byte_packer.sv
// Buffers 24-bit I/Q pairs and serialises each into six bytes on a valid/ready stream.
// Strobe to first byte: two cycles; output held while stalled, input drops counted when full.
module iq_byte_packer
    import iq_byte_packer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    iq_byte_packer_if.slave             bus,
    input  logic                        clear_overflow,
    output logic                        overflow,
    output logic [CNT_WIDTH-1:0]        overflow_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [PAIR_WIDTH-1:0] fifo_dat;

    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [PAIR_WIDTH-1:0] hold_q, hold_d;
    logic [7:0]            out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_first_q, out_first_d;
    logic                  out_last_q, out_last_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]  overflow_count_q, overflow_count_d;
    logic                  out_en;

    assign drop      = bus.in_strobe && fifo_full;
    assign fifo_push = bus.in_strobe && !fifo_full;

    iq_fifo #(
        .WIDTH (PAIR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clock),
        .rst      (reset),
        .push     (fifo_push),
        .push_dat ({bus.in_data_I, bus.in_data_Q}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // The output register may take a new byte when empty or being consumed this cycle.
    assign out_en = !out_valid_q || bus.out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        fifo_pop    = 1'b0;

        if (out_en) begin
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_dat;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_en) begin
                    out_data_d  = pair_byte(hold_q, idx_q);
                    out_valid_d = 1'b1;
                    out_first_d = (idx_q == '0);
                    out_last_d  = (idx_q == LAST_IDX);
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // Reload straight from the FIFO so the next pair follows with no bubble.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            hold_d   = fifo_dat;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A drop coinciding with a clear leaves exactly that one drop recorded.
    always_comb begin
        overflow_d       = overflow_q;
        overflow_count_d = overflow_count_q;
        if (clear_overflow) begin
            overflow_d       = drop;
            overflow_count_d = drop ? CNT_WIDTH'(1) : '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (overflow_count_q != '1)
                overflow_count_d = overflow_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            hold_q           <= '0;
            out_data_q       <= '0;
            out_valid_q      <= 1'b0;
            out_first_q      <= 1'b0;
            out_last_q       <= 1'b0;
            overflow_q       <= 1'b0;
            overflow_count_q <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            hold_q           <= hold_d;
            out_data_q       <= out_data_d;
            out_valid_q      <= out_valid_d;
            out_first_q      <= out_first_d;
            out_last_q       <= out_last_d;
            overflow_q       <= overflow_d;
            overflow_count_q <= overflow_count_d;
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_first   = out_first_q;
    assign bus.out_last    = out_last_q;
    assign overflow        = overflow_q;
    assign overflow_count  = overflow_count_q;

endmodule

// File: tb/tb_iq_byte_packer.sv
// Directed bench for iq_byte_packer: latency, back-to-back, stalls, overflow, saturation, reset.
module tb_iq_byte_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear_overflow;
    logic        overflow;
    logic [15:0] overflow_count;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    iq_byte_packer_if bus ();

    iq_byte_packer dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .clear_overflow (clear_overflow),
        .overflow       (overflow),
        .overflow_count (overflow_count),
        .fifo_level     (fifo_level)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_pair(input logic [23:0] i, input logic [23:0] q);
        bus.in_strobe = 1'b1;
        bus.in_data_I = i;
        bus.in_data_Q = q;
        tick();
        bus.in_strobe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        if (!bus.out_valid) chk(tag, 32'd0, 32'd1);
    endtask

    logic [7:0] exp_a [6]  = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    logic [7:0] exp_b [12] = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF,
                               8'h01, 8'h02, 8'h03, 8'hFE, 8'hDC, 8'hBA};
    logic [7:0] exp_c [6]  = '{8'h7F, 8'h80, 8'h01, 8'h00, 8'hFF, 8'h10};
    logic [7:0] exp_d [6]  = '{8'hA5, 8'hC3, 8'h96, 8'h5A, 8'h3C, 8'h69};
    logic       rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int k;
        int c;
        int pairs;
        logic seen;

        reset          = 1'b1;
        clear_overflow = 1'b0;
        bus.in_strobe  = 1'b1;
        bus.in_data_I  = 24'h111111;
        bus.in_data_Q  = 24'h222222;
        bus.out_ready  = 1'b1;
        tick();
        tick();
        bus.in_strobe = 1'b0;
        reset = 1'b0;

        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_first", 32'(bus.out_first), 32'd0);
        chk("rst_last",  32'(bus.out_last),  32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_level", 32'(fifo_level),    32'd0);
        chk("rst_ovf",   32'(overflow),      32'd0);
        chk("rst_cnt",   32'(overflow_count), 32'd0);

        // Single pair: strobe at edge N, byte 0 visible after edge N+2.
        push_pair(24'h123456, 24'hABCDEF);
        chk("lat_n_level", 32'(fifo_level), 32'd1);
        chk("lat_n_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("lat_n1_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_n1_level", 32'(fifo_level), 32'd0);
        tick();
        for (int b = 0; b < 6; b++) begin
            chk("single_valid", 32'(bus.out_valid), 32'd1);
            chk("single_data",  32'(bus.out_data),  32'(exp_a[b]));
            chk("single_first", 32'(bus.out_first), 32'(b == 0));
            chk("single_last",  32'(bus.out_last),  32'(b == 5));
            tick();
        end
        chk("single_end_valid", 32'(bus.out_valid), 32'd0);

        // Two pairs strobed back to back must stream 12 bytes with no gap.
        push_pair(24'h123456, 24'hABCDEF);
        push_pair(24'h010203, 24'hFEDCBA);
        wait_valid("b2b_timeout", 10);
        for (int b = 0; b < 12; b++) begin
            chk("b2b_valid", 32'(bus.out_valid), 32'd1);
            chk("b2b_data",  32'(bus.out_data),  32'(exp_b[b]));
            chk("b2b_first", 32'(bus.out_first), 32'(b == 0 || b == 6));
            chk("b2b_last",  32'(bus.out_last),  32'(b == 5 || b == 11));
            tick();
        end
        chk("b2b_end_valid", 32'(bus.out_valid), 32'd0);

        // Stalls with ready pattern 1,0,0,1: the byte under test only advances on a handshake.
        push_pair(24'h7F8001, 24'h00FF10);
        k = 0;
        c = 0;
        while (k < 6 && c < 60) begin
            bus.out_ready = rdy_pat[c % 4];
            if (bus.out_valid) begin
                chk("stall_data",  32'(bus.out_data),  32'(exp_c[k]));
                chk("stall_first", 32'(bus.out_first), 32'(k == 0));
                chk("stall_last",  32'(bus.out_last),  32'(k == 5));
                if (bus.out_ready) k++;
            end
            tick();
            c++;
        end
        chk("stall_count", 32'(k), 32'd6);
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            seen |= bus.out_valid;
            tick();
        end
        chk("stall_no_dup", 32'(seen), 32'd0);

        // Overflow: 1 pair in the holding register, 16 in the FIFO, 3 dropped.
        do_reset();
        bus.out_ready = 1'b0;
        for (int n = 0; n < 20; n++) push_pair({8'(n), 16'h0000}, 24'h000000);
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_cnt",   32'(overflow_count), 32'd3);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clr_flag", 32'(overflow), 32'd0);
        chk("clr_cnt",  32'(overflow_count), 32'd0);
        chk("clr_level", 32'(fifo_level), 32'd16);
        clear_overflow = 1'b1;
        push_pair(24'hEEEEEE, 24'hEEEEEE);
        clear_overflow = 1'b0;
        chk("clr_drop_flag", 32'(overflow), 32'd1);
        chk("clr_drop_cnt",  32'(overflow_count), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clr2_cnt", 32'(overflow_count), 32'd0);

        // Saturation of the 16-bit drop counter.
        bus.in_strobe = 1'b1;
        bus.in_data_I = 24'hEEEEEE;
        for (int n = 0; n < 65534; n++) tick();
        bus.in_strobe = 1'b0;
        chk("sat_fffe", 32'(overflow_count), 32'h0000FFFE);
        push_pair(24'hEEEEEE, 24'hEEEEEE);
        chk("sat_ffff", 32'(overflow_count), 32'h0000FFFF);
        for (int n = 0; n < 3; n++) push_pair(24'hEEEEEE, 24'hEEEEEE);
        chk("sat_hold", 32'(overflow_count), 32'h0000FFFF);
        chk("sat_flag", 32'(overflow), 32'd1);
        chk("sat_level", 32'(fifo_level), 32'd16);

        // Drain: exactly the first 17 strobed pairs, in order.
        bus.out_ready = 1'b1;
        pairs = 0;
        for (int n = 0; n < 200; n++) begin
            if (bus.out_valid && bus.out_first) begin
                chk("drain_order", 32'(bus.out_data), 32'(pairs));
                pairs++;
            end
            tick();
        end
        chk("drain_pairs", 32'(pairs), 32'd17);

        // Reset mid-pair with 4 pairs queued discards everything; strobe during reset ignored.
        do_reset();
        for (int n = 0; n < 5; n++)
            push_pair({8'h20 + 8'(n), 8'h30 + 8'(n), 8'h40 + 8'(n)}, 24'h506070);
        c = 0;
        while (!(bus.out_valid && bus.out_data == 8'h40) && c < 20) begin
            tick();
            c++;
        end
        chk("mid_byte2_seen", 32'(bus.out_data), 32'h40);
        chk("mid_level", 32'(fifo_level), 32'd4);
        tick();
        reset         = 1'b1;
        bus.in_strobe = 1'b1;
        bus.in_data_I = 24'h999999;
        tick();
        reset         = 1'b0;
        bus.in_strobe = 1'b0;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            seen |= bus.out_valid;
            tick();
        end
        chk("mid_rst_quiet", 32'(seen), 32'd0);
        push_pair(24'hA5C396, 24'h5A3C69);
        wait_valid("post_rst_timeout", 10);
        for (int b = 0; b < 6; b++) begin
            chk("post_rst_data", 32'(bus.out_data), 32'(exp_d[b]));
            chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
            tick();
        end
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            seen |= bus.out_valid;
            tick();
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
